// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU program-counter slice.
package hack_pkg;

  localparam int unsigned HACK_WIDTH = 16;

  localparam int unsigned JLT = 2;
  localparam int unsigned JEQ = 1;
  localparam int unsigned JGT = 0;

  typedef logic [2:0] jump_t;

endpackage

// File: rtl/hack_gates.sv
// Primitive two-input gates used by the gate-level parts of the Hack CPU.
module hack_and (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a & b;
endmodule

module hack_or (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a | b;
endmodule

module hack_not (
  input  logic in,
  output logic out
);
  assign out = ~in;
endmodule

// File: rtl/hack_jump_cond.sv
// Jump decision from C-instruction jump bits and ALU flags, in gate-level form.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic  c_instr,
  input  jump_t jjj,
  input  logic  zr,
  input  logic  ng,
  output logic  take
);

  logic not_zr, not_ng, pos;
  logic lt_hit, eq_hit, gt_hit;
  logic any_lo, any_hit;

  hack_not u_not_zr (.in(zr), .out(not_zr));
  hack_not u_not_ng (.in(ng), .out(not_ng));

  // Strictly positive: neither zero nor negative.
  hack_and u_pos (.a(not_zr), .b(not_ng), .out(pos));

  hack_and u_lt (.a(jjj[JLT]), .b(ng),  .out(lt_hit));
  hack_and u_eq (.a(jjj[JEQ]), .b(zr),  .out(eq_hit));
  hack_and u_gt (.a(jjj[JGT]), .b(pos), .out(gt_hit));

  hack_or u_or_a (.a(lt_hit), .b(eq_hit), .out(any_lo));
  hack_or u_or_b (.a(any_lo), .b(gt_hit), .out(any_hit));

  hack_and u_take (.a(c_instr), .b(any_hit), .out(take));

endmodule

// File: rtl/hack_pc.sv
// Hack program counter with jump select, retired-instruction counter and self-jump halt detect.
module hack_pc
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset,
  input  logic             en,
  input  logic             c_instr,
  input  logic [2:0]       jjj,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] pc,
  output logic             jump_taken,
  output logic             halt,
  output logic [WIDTH-1:0] retired
);

  logic take;

  hack_jump_cond u_jump_cond (
    .c_instr (c_instr),
    .jjj     (jump_t'(jjj)),
    .zr      (zr),
    .ng      (ng),
    .take    (take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      jump_taken <= 1'b0;
      halt       <= 1'b0;
      retired    <= '0;
    end else if (reset) begin
      pc         <= '0;
      jump_taken <= 1'b0;
      halt       <= 1'b0;
      retired    <= '0;
    end else if (en) begin
      if (take) begin
        pc         <= a_in;
        jump_taken <= 1'b1;
        if (a_in == pc) halt <= 1'b1;
      end else begin
        pc         <= pc + WIDTH'(1);
        jump_taken <= 1'b0;
      end
      // The halting self-jump still counts; halt is the pre-edge value here.
      if (!halt && (retired != '1)) retired <= retired + WIDTH'(1);
    end
  end

endmodule

// File: doc/hack_pc.md
# hack_pc

Program counter stage of the Hack CPU: holds the ROM address of the current instruction and computes the next one from the jump bits of the C-instruction and the ALU status flags (zr, ng). It sits directly downstream of the gate-level combinational logic (AND/OR/NOT) and the ALU, and upstream of the instruction ROM address port. It also provides a retired-instruction counter and a halt detector for the Hack end-of-program idiom: a jump to its own address.

## Interface
- WIDTH, 16, address width of pc and a_in
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- reset  input  1  synchronous Hack reset; forces pc to 0 on the next edge
- en  input  1  advance enable; 0 stalls every register
- c_instr  input  1  current instruction is a C-instruction (instr[15])
- jjj  input  3  jump bits: jjj[2]=JLT, jjj[1]=JEQ, jjj[0]=JGT
- zr  input  1  ALU output equals zero
- ng  input  1  ALU output is negative
- a_in  input  WIDTH  current A-register value, used as the jump target
- pc  output  WIDTH  address of the current instruction
- jump_taken  output  1  registered; 1 for one cycle after a taken jump
- halt  output  1  registered sticky flag; self-jump detected
- retired  output  WIDTH  count of advanced instructions, saturating

## Operation
- Jump condition: take = c_instr & ((jjj[2]&ng) | (jjj[1]&zr) | (jjj[0]&~zr&~ng)).
- jjj=3'b111 is an unconditional jump. jjj=3'b000 never jumps. zr=ng=1 is illegal from the ALU; treat it per the formula.
- Next-pc priority on each rising clk:
  1. reset=1: pc←0, jump_taken←0, halt←0, retired←0. This applies regardless of en.
  2. en=0: all registers hold.
  3. take=1: pc←a_in, jump_taken←1.
  4. Otherwise: pc←pc+1 modulo 2^WIDTH, jump_taken←0.
- Wrap-around: pc = all-ones with no jump gives pc=0. No flag is raised.
- halt: set when en=1, reset=0, take=1 and a_in==pc. Once set it stays set until reset or rst_n. pc keeps being loaded with a_in while halted, so the pc value does not change.
- retired: increments on every edge where en=1 and reset=0 and halt is 0 before the edge. It saturates at all-ones and never wraps.
- When halt becomes 1 on an edge, that edge still counts the self-jump instruction. Later edges do not count.
- A-instructions (c_instr=0) never jump, regardless of jjj, zr or ng.

## Timing
- rst_n low: pc, jump_taken, halt and retired go to 0 immediately. This is asynchronous and independent of clk.
- rst_n deassertion is synchronised by the system. The block only requires that rst_n is released away from a clk edge.
- One-cycle latency: inputs sampled at edge N determine pc after edge N.
- The path to the next pc is fully combinational. There is no pipeline bubble on a jump.
- jump_taken is high for exactly the cycle after the edge that loaded a_in. If jumps occur back-to-back, it stays high.
- reset and take in the same cycle: reset wins, pc=0.
- en=0 and reset=1 in the same cycle: reset wins.
- rst_n asserted mid-run, including while halted: all outputs return to 0. After release, execution restarts at pc=0.

## Structure
- Package hack_pkg holds:
  - the WIDTH default constant
  - the jjj bit-index constants JLT=2, JEQ=1, JGT=0
  - a 3-bit jump typedef
- Sub-module hack_jump_cond is combinational: inputs c_instr, jjj, zr, ng; output take. It is built from the team's gate modules (AND, OR, NOT) so it matches the gate-level style of the CPU.
- hack_pc instantiates hack_jump_cond and holds the four registers: pc, jump_taken, halt, retired.

## Test plan
- Sequential run: rst_n pulse, en=1, c_instr=0 for 5 cycles → pc goes 0,1,2,3,4,5; retired=5; jump_taken=0.
- Jump decode: pc=10, a_in=100, c_instr=1. Sweep all 8 jjj values against (zr,ng) = (0,0), (1,0), (0,1). Each → pc=100 only where the formula is true, otherwise pc=11. jump_taken matches the next cycle.
- Wrap: load pc=16'hFFFF via a jump, then no jump → pc=0, retired keeps incrementing, halt=0.
- Halt: pc=20, a_in=20, jjj=3'b111, c_instr=1 → halt=1 after the edge, pc stays 20, retired frozen at its value after that edge for 10 more cycles.
- Stall and priority:
  - en=0 for 3 cycles → pc and retired unchanged.
  - reset=1 together with a taken jump → pc=0, halt=0, retired=0.
- Async reset: assert rst_n low between clk edges while pc=37 and halt=1 → all outputs 0 before the next edge. After release, pc counts from 0.
